// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock)
module bcd_to_bin_seq #(
    parameter int NDIG = 2,
    parameter int BW   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW-1:0]     bin_out,
    output logic              err
);

    localparam int SW = 4*NDIG + BW;
    localparam int CW = $clog2(BW) + 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bin_q, bin_d;
    logic            err_q, err_d;
    logic            bad_digit;
    logic [SW-1:0]   shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        err_d     = err_q;
        bad_digit = 1'b0;
        shifted   = sr_q >> 1;

        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end

        // Digits of 8..12 appear after the shift; each corrects independently with no borrow.
        for (int i = 0; i < NDIG; i++) begin
            if (shifted[BW + 4*i +: 4] >= 4'd8) begin
                shifted[BW + 4*i +: 4] = shifted[BW + 4*i +: 4] - 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        bin_d   = '0;
                        state_d = DONE;
                    end else begin
                        sr_d    = {bcd_in, {BW{1'b0}}};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sr_d  = shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BW - 1)) begin
                    bin_d   = shifted[BW-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bin_out   = bin_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - self-checking bench for bcd_to_bin_seq (2-digit and 4-digit instances)
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  bin_out;
    logic        err;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [15:0] w_bcd_in;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [13:0] w_bin_out;
    logic        w_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0] bin;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] bin;
        logic       err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.NDIG(2), .BW(7)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    bcd_to_bin_seq #(.NDIG(4), .BW(14)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .bcd_in    (w_bcd_in),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .bin_out   (w_bin_out),
        .err       (w_err)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: a result is taken on every edge where out_valid && out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", out_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bin_out", bin_out, e.bin);
                chk("err", err, e.err);
                if (!err) begin
                    chk("bcd_remainder", u_dut.sr_q[14:7], 0);
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", in_ready, 1);
    endtask

    task automatic send_timed(input logic [7:0] b, input logic [6:0] eb, input logic e, input int lat);
        int n;
        wait_ready();
        in_valid = 1'b1;
        bcd_in   = b;
        sb.push_back('{bin: eb, err: e});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{8'h00, 7'd0,  1'b0};
        vecs[1] = '{8'h45, 7'd45, 1'b0};
        vecs[2] = '{8'h10, 7'd10, 1'b0};
        vecs[3] = '{8'h09, 7'd9,  1'b0};
        vecs[4] = '{8'h81, 7'd81, 1'b0};
        vecs[5] = '{8'hA0, 7'd0,  1'b1};
        vecs[6] = '{8'h36, 7'd36, 1'b0};
        vecs[7] = '{8'h99, 7'd99, 1'b0};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        bcd_in      = '0;
        out_ready   = 1'b1;
        w_in_valid  = 1'b0;
        w_bcd_in    = '0;
        w_out_ready = 1'b1;
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_bin_out", bin_out, 0);
        chk("reset_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Maximum two-digit input, full latency, in_ready returns after handoff
        send_timed(8'h99, 7'd99, 1'b0, 8);
        @(posedge clk); #1;
        chk("in_ready_after_handoff", in_ready, 1);

        // Back-to-back table with in_valid held high
        for (int i = 0; i < 8; i++) begin
            int t = 0;
            in_valid = 1'b1;
            bcd_in   = vecs[i].bcd;
            while (!in_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            chk("table_ready", in_ready, 1);
            sb.push_back('{bin: vecs[i].bin, err: vecs[i].err});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Invalid digit then recovery
        send_timed(8'h3A, 7'd0, 1'b1, 1);
        send_timed(8'h27, 7'd27, 1'b0, 8);
        drain();

        // Backpressure: result held, inputs ignored
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        bcd_in   = 8'h58;
        sb.push_back('{bin: 7'd58, err: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            bcd_in   = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            chk("bp_bin_hold", bin_out, 58);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid_hold", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handoff_out_valid", out_valid, 0);
        chk("bp_handoff_in_ready", in_ready, 1);
        chk("bp_bin_retained", bin_out, 58);
        chk("bp_queue_empty", sb.size(), 0);

        // Asynchronous reset during conversion aborts it
        wait_ready();
        in_valid = 1'b1;
        bcd_in   = 8'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_bin_out", bin_out, 0);
        chk("abort_err", err, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_no_output", out_valid, 0);
        end
        send_timed(8'h12, 7'd12, 1'b0, 8);
        drain();

        // Four-digit instance
        w_in_valid = 1'b1;
        w_bcd_in   = 16'h9999;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 1;
        while (!w_out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w_latency", n, 15);
        chk("w_bin_9999", w_bin_out, 9999);
        chk("w_err_9999", w_err, 0);
        @(posedge clk); #1;
        chk("w_in_ready", w_in_ready, 1);
        w_in_valid = 1'b1;
        w_bcd_in   = 16'h0400;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 1;
        while (!w_out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w_bin_400", w_bin_out, 400);
        chk("w_err_400", w_err, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
